// File: rtl/ooo_pkg.sv
// Shared rename-stage definitions: register-file sizes, physical tag type and
// the free-list controller state encoding.
package ooo_pkg;

   localparam int NUM_PHYS = 64;
   localparam int NUM_ARCH = 32;
   localparam int TAG_W    = 6;

   typedef logic [TAG_W-1:0] phys_tag_t;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } fl_state_t;

endpackage

// File: rtl/free_list_fifo.sv
// Two-write / two-read circular buffer of physical tags with head/tail pointers
// that wrap modulo DEPTH and an occupancy count.
module free_list_fifo
   import ooo_pkg::*;
#(
   parameter int DEPTH = NUM_PHYS,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en_1,
   input  logic             wr_en_2,
   input  phys_tag_t        wr_tag_1,
   input  phys_tag_t        wr_tag_2,
   input  logic [1:0]       rd_cnt,
   output phys_tag_t        rd_tag_1,
   output phys_tag_t        rd_tag_2,
   output logic [CNT_W-1:0] count
);

   localparam int             PTR_W   = $clog2(DEPTH);
   localparam logic [PTR_W:0] DEPTH_W = (PTR_W + 1)'(DEPTH);

   phys_tag_t        mem [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W-1:0] head_1;
   logic [PTR_W-1:0] tail_1;
   logic [1:0]       wr_cnt;
   phys_tag_t        wr_first;

   function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] ptr,
                                                input logic [1:0]       inc);
      logic [PTR_W:0] sum;
      sum = {1'b0, ptr} + {{(PTR_W - 1){1'b0}}, inc};
      if (sum >= DEPTH_W) begin
         sum = sum - DEPTH_W;
      end else begin
         sum = sum;
      end
      return sum[PTR_W-1:0];
   endfunction

   // Write compaction (a lone slot-2 free lands at tail) and read ports
   always_comb begin
      wr_cnt   = {1'b0, wr_en_1} + {1'b0, wr_en_2};
      wr_first = wr_en_1 ? wr_tag_1 : wr_tag_2;
      head_1   = ptr_add(head, 2'd1);
      tail_1   = ptr_add(tail, 2'd1);
      rd_tag_1 = mem[head];
      rd_tag_2 = mem[head_1];
   end

   // Tag storage
   always_ff @(posedge clk) begin
      if (wr_cnt != 2'd0) begin
         mem[tail] <= wr_first;
      end
      if (wr_en_1 && wr_en_2) begin
         mem[tail_1] <= wr_tag_2;
      end
   end

   // Pointer and occupancy state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head  <= {PTR_W{1'b0}};
         tail  <= {PTR_W{1'b0}};
         count <= {CNT_W{1'b0}};
      end else begin
         head  <= ptr_add(head, rd_cnt);
         tail  <= ptr_add(tail, wr_cnt);
         count <= count - CNT_W'(rd_cnt) + CNT_W'(wr_cnt);
      end
   end

endmodule

// File: rtl/free_list_ctrl.sv
// Physical-register free list: INIT fill, all-or-nothing dual allocation, retire frees.
// Optional FREE_LIST_BITMAP_EN adds the free_regs occupancy bitmap output.
module free_list_ctrl
   import ooo_pkg::phys_tag_t, ooo_pkg::fl_state_t, ooo_pkg::ST_INIT, ooo_pkg::ST_RUN;
#(
   parameter int NUM_PHYS = ooo_pkg::NUM_PHYS,
   parameter int NUM_ARCH = ooo_pkg::NUM_ARCH
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             alloc_req_1,
   input  logic                             alloc_req_2,
   output phys_tag_t                        alloc_tag_1,
   output phys_tag_t                        alloc_tag_2,
   output logic                             alloc_grant,
   output logic                             alloc_stall,
   input  logic                             free_en_1,
   input  logic                             free_en_2,
   input  phys_tag_t                        free_tag_1,
   input  phys_tag_t                        free_tag_2,
   output logic [$clog2(NUM_PHYS + 1)-1:0]  free_count,
   output logic                             ready,
   output logic                             overflow_err
`ifdef FREE_LIST_BITMAP_EN
   ,
   output logic [NUM_PHYS-1:0]              free_regs
`endif
);

   localparam int             CNT_W  = $clog2(NUM_PHYS + 1);
   localparam logic [CNT_W:0] PHYS_W = (CNT_W + 1)'(NUM_PHYS);

   fl_state_t        state;
   logic [CNT_W-1:0] init_tag;
   logic [CNT_W:0]   init_end;
   logic [CNT_W:0]   room;
   logic [1:0]       need;
   logic [1:0]       rd_cnt;
   logic             wr_en_1;
   logic             wr_en_2;
   phys_tag_t        wr_tag_1;
   phys_tag_t        wr_tag_2;
   phys_tag_t        rd_tag_1;
   phys_tag_t        rd_tag_2;
   logic             valid_1;
   logic             valid_2;
   logic             drop;

   // Grant/stall decision and zero-latency tag presentation
   always_comb begin
      need = {1'b0, alloc_req_1} + {1'b0, alloc_req_2};
      if ((state == ST_RUN) && (need != 2'd0) && (free_count >= CNT_W'(need))) begin
         alloc_grant = 1'b1;
      end else begin
         alloc_grant = 1'b0;
      end
      alloc_stall = (need != 2'd0) && !alloc_grant;
      rd_cnt      = alloc_grant ? need : 2'd0;
      if ((state == ST_RUN) && alloc_req_1) begin
         alloc_tag_1 = rd_tag_1;
      end else begin
         alloc_tag_1 = 6'd0;
      end
      if ((state == ST_RUN) && alloc_req_2) begin
         alloc_tag_2 = alloc_req_1 ? rd_tag_2 : rd_tag_1;
      end else begin
         alloc_tag_2 = 6'd0;
      end
   end

   // Write selection; room counts slots vacated by this cycle's grant, never same-cycle frees
   always_comb begin
      valid_1  = free_en_1 && (free_tag_1 != 6'd0);
      valid_2  = free_en_2 && (free_tag_2 != 6'd0);
      room     = PHYS_W - {1'b0, free_count} + (CNT_W + 1)'(rd_cnt);
      init_end = {1'b0, init_tag} + (CNT_W + 1)'(1);
      if (state == ST_INIT) begin
         wr_en_1  = 1'b1;
         wr_tag_1 = phys_tag_t'(init_tag);
         wr_en_2  = (init_end < PHYS_W);
         wr_tag_2 = phys_tag_t'(init_end);
         drop     = 1'b0;
      end else begin
         wr_en_1  = valid_1 && (room != (CNT_W + 1)'(0));
         wr_tag_1 = free_tag_1;
         wr_en_2  = valid_2 && (room > (CNT_W + 1)'(wr_en_1));
         wr_tag_2 = free_tag_2;
         drop     = (valid_1 && !wr_en_1) || (valid_2 && !wr_en_2);
      end
   end

   // Controller FSM with registered ready and sticky overflow
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_INIT;
         init_tag     <= CNT_W'(NUM_ARCH);
         ready        <= 1'b0;
         overflow_err <= 1'b0;
      end else begin
         case (state)
            ST_INIT: begin
               init_tag <= init_tag + CNT_W'(2);
               if (({1'b0, init_tag} + (CNT_W + 1)'(2)) >= PHYS_W) begin
                  state <= ST_RUN;
                  ready <= 1'b1;
               end
            end
            ST_RUN: begin
               if (drop) begin
                  overflow_err <= 1'b1;
               end
            end
            default: begin
               state <= ST_INIT;
               ready <= 1'b0;
            end
         endcase
      end
   end

   free_list_fifo #(
      .DEPTH (NUM_PHYS)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr_en_1  (wr_en_1),
      .wr_en_2  (wr_en_2),
      .wr_tag_1 (wr_tag_1),
      .wr_tag_2 (wr_tag_2),
      .rd_cnt   (rd_cnt),
      .rd_tag_1 (rd_tag_1),
      .rd_tag_2 (rd_tag_2),
      .count    (free_count)
   );

`ifdef FREE_LIST_BITMAP_EN
   localparam logic [NUM_PHYS-1:0] BIT_ONE  = NUM_PHYS'(1);
   localparam logic [NUM_PHYS-1:0] BIT_ZERO = NUM_PHYS'(0);

   logic [NUM_PHYS-1:0] clr_mask;
   logic [NUM_PHYS-1:0] set_mask;

   // Bitmap edits mirror exactly the tags leaving and entering the FIFO
   always_comb begin
      clr_mask = ((rd_cnt != 2'd0) ? (BIT_ONE << rd_tag_1) : BIT_ZERO)
               | ((rd_cnt == 2'd2) ? (BIT_ONE << rd_tag_2) : BIT_ZERO);
      set_mask = (wr_en_1 ? (BIT_ONE << wr_tag_1) : BIT_ZERO)
               | (wr_en_2 ? (BIT_ONE << wr_tag_2) : BIT_ZERO);
   end

   // Occupancy bitmap register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         free_regs <= BIT_ZERO;
      end else begin
         free_regs <= (free_regs & ~clr_mask) | set_mask;
      end
   end
`endif

endmodule

// File: tb/tb_free_list_ctrl.sv
// Randomized and directed bench for free_list_ctrl against a queue-based list model.
module tb_free_list_ctrl;

   localparam int NP = 64;
   localparam int NA = 32;

   logic       clk;
   logic       reset;
   logic       alloc_req_1;
   logic       alloc_req_2;
   logic [5:0] alloc_tag_1;
   logic [5:0] alloc_tag_2;
   logic       alloc_grant;
   logic       alloc_stall;
   logic       free_en_1;
   logic       free_en_2;
   logic [5:0] free_tag_1;
   logic [5:0] free_tag_2;
   logic [6:0] free_count;
   logic       ready;
   logic       overflow_err;
`ifdef FREE_LIST_BITMAP_EN
   logic [NP-1:0] free_regs;
`endif

   free_list_ctrl #(.NUM_PHYS(NP), .NUM_ARCH(NA)) dut (
      .clk          (clk),
      .reset        (reset),
      .alloc_req_1  (alloc_req_1),
      .alloc_req_2  (alloc_req_2),
      .alloc_tag_1  (alloc_tag_1),
      .alloc_tag_2  (alloc_tag_2),
      .alloc_grant  (alloc_grant),
      .alloc_stall  (alloc_stall),
      .free_en_1    (free_en_1),
      .free_en_2    (free_en_2),
      .free_tag_1   (free_tag_1),
      .free_tag_2   (free_tag_2),
      .free_count   (free_count),
      .ready        (ready),
      .overflow_err (overflow_err)
`ifdef FREE_LIST_BITMAP_EN
      ,
      .free_regs    (free_regs)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Model: the free list as an ordered queue of tags, plus tags held by the pipeline.
   int m_q[$];
   int outs[$];
   bit m_run;
   int m_init;
   bit m_ovf;
   bit p_gnt;
   int p_need;

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      m_q.delete();
      outs.delete();
      for (int i = 1; i < NA; i++) outs.push_back(i);
      m_run  = 1'b0;
      m_init = NA;
      m_ovf  = 1'b0;
   endfunction

   function automatic void out_remove(input int t);
      for (int i = 0; i < outs.size(); i++) begin
         if (outs[i] == t) begin
            outs.delete(i);
            return;
         end
      end
   endfunction

`ifdef FREE_LIST_BITMAP_EN
   function automatic logic [63:0] model_bitmap();
      logic [63:0] b;
      b = 64'd0;
      foreach (m_q[i]) b[m_q[i]] = 1'b1;
      return b;
   endfunction
`endif

   // Apply inputs for one cycle and compare outputs at mid-cycle.
   task automatic cyc_check(input logic r1, input logic r2, input logic f1, input logic [5:0] t1,
                            input logic f2, input logic [5:0] t2);
      alloc_req_1 = r1;
      alloc_req_2 = r2;
      free_en_1   = f1;
      free_tag_1  = t1;
      free_en_2   = f2;
      free_tag_2  = t2;
      #4;
      p_need = int'(r1) + int'(r2);
      p_gnt  = m_run && (p_need > 0) && (m_q.size() >= p_need);
      check_value("grant", 64'(alloc_grant), 64'(p_gnt));
      check_value("stall", 64'(alloc_stall), 64'((p_need > 0) && !p_gnt));
      check_value("ready", 64'(ready), 64'(m_run));
      check_value("count", 64'(free_count), 64'(m_q.size()));
      check_value("overflow", 64'(overflow_err), 64'(m_ovf));
      if (!r1) check_value("tag1_idle", 64'(alloc_tag_1), 64'd0);
      if (!r2) check_value("tag2_idle", 64'(alloc_tag_2), 64'd0);
      if (p_gnt && r1) check_value("tag1", 64'(alloc_tag_1), 64'(m_q[0]));
      if (p_gnt && r2) check_value("tag2", 64'(alloc_tag_2), 64'(r1 ? m_q[1] : m_q[0]));
`ifdef FREE_LIST_BITMAP_EN
      check_value("bitmap", free_regs, model_bitmap());
`endif
   endtask

   // Clock edge and model update from the inputs applied by cyc_check.
   task automatic cyc_edge();
      @(posedge clk);
      if (!m_run) begin
         for (int k = 0; k < 2; k++) begin
            if (m_init < NP) begin
               m_q.push_back(m_init);
               m_init++;
            end
         end
         if (m_init >= NP) m_run = 1'b1;
      end else begin
         if (p_gnt) begin
            for (int k = 0; k < p_need; k++) outs.push_back(m_q.pop_front());
         end
         if (free_en_1 && free_tag_1 != 6'd0) begin
            if (m_q.size() < NP) m_q.push_back(int'(free_tag_1));
            else m_ovf = 1'b1;
         end
         if (free_en_2 && free_tag_2 != 6'd0) begin
            if (m_q.size() < NP) m_q.push_back(int'(free_tag_2));
            else m_ovf = 1'b1;
         end
      end
      #1;
   endtask

   task automatic pick_free(output logic en, output logic [5:0] tag);
      int idx;
      if (outs.size() > 0 && $urandom_range(0, 2) == 0) begin
         idx = $urandom_range(0, outs.size() - 1);
         tag = 6'(outs[idx]);
         outs.delete(idx);
         en  = 1'b1;
      end else if ($urandom_range(0, 15) == 0) begin
         en  = 1'b1;
         tag = 6'd0;
      end else begin
         en  = 1'b0;
         tag = 6'($urandom_range(0, 63));
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_value({tag, "_grant"}, 64'(alloc_grant), 64'd0);
      check_value({tag, "_tag1"}, 64'(alloc_tag_1), 64'd0);
      check_value({tag, "_tag2"}, 64'(alloc_tag_2), 64'd0);
      check_value({tag, "_count"}, 64'(free_count), 64'd0);
      check_value({tag, "_ready"}, 64'(ready), 64'd0);
      check_value({tag, "_ovf"}, 64'(overflow_err), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       f1, f2;
      logic [5:0] t1, t2;
      reset = 1'b1;
      alloc_req_1 = 1'b0; alloc_req_2 = 1'b0;
      free_en_1 = 1'b0; free_en_2 = 1'b0; free_tag_1 = 6'd0; free_tag_2 = 6'd0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      alloc_req_1 = 1'b1; alloc_req_2 = 1'b1;
      #1;
      check_reset_outputs("rst");
      alloc_req_1 = 1'b0; alloc_req_2 = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;

      // INIT: requests must stall and frees are ignored
      for (int i = 0; i < 16; i++) begin
         cyc_check(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
                   6'($urandom_range(1, 63)), 1'b0, 6'd0);
         cyc_edge();
      end
      cyc_check(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
      check_value("init_ready", 64'(ready), 64'd1);
      check_value("init_count", 64'(free_count), 64'd32);
`ifdef FREE_LIST_BITMAP_EN
      check_value("init_bitmap", free_regs, 64'hFFFF_FFFF_0000_0000);
`endif
      cyc_edge();

      // Drain with dual requests
      for (int k = 0; k < 16; k++) begin
         cyc_check(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
         check_value("drain_tag1", 64'(alloc_tag_1), 64'(32 + 2 * k));
         check_value("drain_tag2", 64'(alloc_tag_2), 64'(33 + 2 * k));
         cyc_edge();
      end
      cyc_check(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
      check_value("empty_stall", 64'(alloc_stall), 64'd1);
      check_value("empty_grant", 64'(alloc_grant), 64'd0);
      check_value("empty_count", 64'(free_count), 64'd0);
      cyc_edge();

      // No bypass: same-cycle frees do not relieve an empty stall
      out_remove(40); out_remove(41);
      cyc_check(1'b1, 1'b1, 1'b1, 6'd40, 1'b1, 6'd41);
      check_value("nobypass_stall", 64'(alloc_stall), 64'd1);
      cyc_edge();
      cyc_check(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
      check_value("bypass_next_grant", 64'(alloc_grant), 64'd1);
      check_value("bypass_next_tag1", 64'(alloc_tag_1), 64'd40);
      check_value("bypass_next_tag2", 64'(alloc_tag_2), 64'd41);
      cyc_edge();

      // Single entry: dual request refused, single request served
      out_remove(40);
      cyc_check(1'b0, 1'b0, 1'b1, 6'd40, 1'b0, 6'd0);
      cyc_edge();
      cyc_check(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
      check_value("one_stall", 64'(alloc_stall), 64'd1);
      check_value("one_count", 64'(free_count), 64'd1);
      cyc_edge();
      cyc_check(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
      check_value("one_grant", 64'(alloc_grant), 64'd1);
      check_value("one_tag1", 64'(alloc_tag_1), 64'd40);
      cyc_edge();
      cyc_check(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
      check_value("one_count_after", 64'(free_count), 64'd0);
      cyc_edge();

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         pick_free(f1, t1);
         pick_free(f2, t2);
         cyc_check(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), f1, t1, f2, t2);
         cyc_edge();
      end

      // Reset mid-run with a grant in flight
      cyc_check(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
      #1;
      reset = 1'b1;
      #1;
      check_reset_outputs("midrst");
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 16; i++) begin
         cyc_check(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
         cyc_edge();
      end
      cyc_check(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
      check_value("restart_tag1", 64'(alloc_tag_1), 64'd32);
      check_value("restart_tag2", 64'(alloc_tag_2), 64'd33);
      cyc_edge();
      out_remove(32); out_remove(33);
      cyc_check(1'b0, 1'b0, 1'b1, 6'd32, 1'b1, 6'd33);
      cyc_edge();

      // Tag 0 frees are ignored; overflow past a full list is dropped and sticky
      cyc_check(1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 6'd0);
      cyc_edge();
      cyc_check(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
      check_value("tag0_count", 64'(free_count), 64'd32);
      cyc_edge();
      for (int k = 0; k < 16; k++) begin
         cyc_check(1'b0, 1'b0, 1'b1, 6'(2 * k + 1), 1'b1, 6'(2 * k + 2));
         cyc_edge();
      end
      cyc_check(1'b0, 1'b0, 1'b1, 6'd5, 1'b0, 6'd0);
      check_value("full_count", 64'(free_count), 64'd64);
      check_value("full_ovf", 64'(overflow_err), 64'd0);
      cyc_edge();
      cyc_check(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
      check_value("ovf_set", 64'(overflow_err), 64'd1);
      check_value("ovf_count", 64'(free_count), 64'd64);
      cyc_edge();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/free_list_ctrl.md
FREE_LIST_CTRL -- requirements
Module: free_list_ctrl

Interface
REQ-001 SHALL have parameter NUM_PHYS, default 64, the number of physical registers.
REQ-002 SHALL have parameter NUM_ARCH, default 32, the number of architectural registers; tags 0..NUM_ARCH-1 are mapped at reset.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports alloc_req_1, alloc_req_2  in  1 each  rename slot 1/2 needs a destination tag this cycle.
REQ-006 SHALL have ports alloc_tag_1, alloc_tag_2  out  6 each  granted physical tags.
REQ-007 SHALL have ports alloc_grant and alloc_stall  out  1 each  request accepted / request refused this cycle.
REQ-008 SHALL have ports free_en_1, free_en_2  in  1 each, and free_tag_1, free_tag_2  in  6 each  tags returned at retire.
REQ-009 SHALL have ports free_count  out  7  entries held; ready  out  1  initialisation done; overflow_err  out  1  sticky error.

Function
REQ-010 SHALL hold free tags in a circular FIFO of NUM_PHYS entries with head/tail pointers that wrap modulo NUM_PHYS.
REQ-011 SHALL run FSM INIT -> RUN; INIT writes tags NUM_ARCH..NUM_PHYS-1 two per cycle in ascending order (16 cycles at defaults), then moves to RUN with ready=1.
REQ-012 SHALL, while in INIT, drive alloc_stall=1 whenever any alloc_req is high, and ignore free_en.
REQ-013 SHALL compute need = alloc_req_1 + alloc_req_2 and grant all-or-nothing: alloc_grant=1 iff RUN, need>0 and free_count>=need.
REQ-014 SHALL drive alloc_stall=1 iff need>0 and alloc_grant=0; stall and grant are never both high.
REQ-015 SHALL present tags combinationally, zero latency: the lowest requesting slot gets fifo[head], slot 2 gets fifo[head+1] when both request; a non-requesting slot outputs 0.
REQ-016 SHALL, on a granted edge, advance head by need.
REQ-017 SHALL, on an edge, write enabled frees at tail (slot 1 first) and advance tail by the number written.
REQ-018 SHALL update free_count = free_count - granted + written on the same edge.
REQ-019 SHALL not bypass frees: a tag freed in cycle N is allocatable no earlier than cycle N+1, and an empty-list stall is not relieved by same-cycle frees.
REQ-020 SHALL ignore a free of tag 0, with no write and no count change.
REQ-021 SHALL drop any free that would push free_count above NUM_PHYS and set overflow_err until reset.

Reset
REQ-022 SHALL on reset asynchronously clear head, tail, free_count, overflow_err, ready, alloc_grant and the tag outputs to 0, and enter INIT; reset mid-operation discards all pending grants and frees.

Configuration
REQ-023 SHALL, with FREE_LIST_BITMAP_EN defined, add output free_regs (NUM_PHYS bits): bit i is 1 iff tag i is in the list, it is 0 at reset, it tracks INIT fills, and it is updated on the same edge as free_count.
REQ-024 SHALL, without FREE_LIST_BITMAP_EN, omit the free_regs port and all its logic, with behaviour otherwise identical.

Structure
REQ-025 SHALL place NUM_PHYS, NUM_ARCH, the phys-tag typedef (6 bits) and the FSM state enum in shared package ooo_pkg.
REQ-026 SHALL use one sub-module, free_list_fifo: a 2-write/2-read circular buffer with pointers and count; the FSM and grant logic stay in free_list_ctrl.

Verification
REQ-027 SHALL cover: reset released -> ready=0 for 16 cycles, then ready=1, free_count=32 (free_regs=0xFFFFFFFF00000000 with macro).
REQ-028 SHALL cover: both requests every cycle -> tags (32,33),(34,35)...(62,63); in the 17th cycle alloc_stall=1, alloc_grant=0, free_count=0.
REQ-029 SHALL cover: free_count=1 with both requests -> stall, count stays 1; then alloc_req_1 only -> alloc_tag_1=remaining tag, count 0.
REQ-030 SHALL cover: free_count=0, free tags 40 and 41 with both requests in the same cycle -> stall; next cycle grant tags 40, 41.
REQ-031 SHALL cover: free_tag_1=0 with free_en_1 -> free_count unchanged; 33 frees at count 32 -> overflow_err=1 and count holds 64.
REQ-032 SHALL cover: reset asserted mid-RUN with grants outstanding -> outputs clear at once, INIT reruns, tags restart at 32.
